// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
//   - sequencer FSM state enum (md_state_e)
//   - MD_ITER_CNT: iterations of the shared shift datapath (one bit per cycle)
//   - op_is_signed(): true for MULT and DIV
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_ITER_CNT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: 64-bit iterative datapath shared by divide and multiply.
//   Divide   : {hi_q, lo_q} = remainder:quotient, restoring division,
//              one quotient bit per step, divisor held in b_q.
//   Multiply : {hi_q, lo_q} = accumulator:multiplier, shift-add,
//              one multiplier bit per step, multiplicand held in b_q.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   load_i             capture operands (hi cleared, lo <= a_i, b_q <= b_i)
//   step_i             perform one iteration
//   is_div_i           1 = divide step, 0 = multiply step
//   a_i, b_i           unsigned magnitudes of the operands
//   hi_o, lo_o         current datapath contents
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;

  // Divide: partial remainder shifted left with the next dividend bit.
  // It is always < 2*divisor, so when the trial subtraction succeeds the
  // difference fits in WIDTH bits and a WIDTH-bit subtract is exact.
  logic [WIDTH:0]   shifted;
  logic             sub_ok;
  // Multiply: accumulator plus (multiplicand if multiplier LSB set).
  logic [WIDTH:0]   sum;

  always_comb begin
    shifted = {hi_q, lo_q[WIDTH-1]};
    sub_ok  = (shifted >= {1'b0, b_q});
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    b_d  = b_q;
    if (load_i) begin
      hi_d = '0;
      lo_d = a_i;
      b_d  = b_i;
    end else if (step_i) begin
      if (is_div_i) begin
        hi_d = sub_ok ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], sub_ok};
      end else begin
        // Shift {carry, sum, multiplier} right by one.
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer for the HI/LO resource.
// Accepts MULT/MULTU/DIV/DIVU from EX, stalls the pipe via busy, and emits
// a one-cycle done pulse with the HI/LO result for write-back. A flush
// aborts any operation in flight without touching HI/LO.
// Build option:
//   MULDIV_ITER_MUL_EN  defined   -> multiply runs on the iterative datapath
//                                    (34-cycle latency, busy high)
//                       undefined -> registered full-width product,
//                                    1-cycle latency, busy stays low
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   start, op          issue request and op code (sampled only in IDLE)
//   src_a, src_b       rs / rt operands
//   flush              abort; returns to IDLE at the next edge
//   busy               MUL, DIV or FIXUP in progress
//   done               one-cycle result-valid pulse
//   hi_out, lo_out     registered HI/LO result
//   state_dbg          current FSM state, for observation only
// Iteration count is MD_ITER_CNT; WIDTH is expected to equal it.
//
// Handshake: start is a level request honoured only when the FSM is idle
// and flush is low; requests at any other time are dropped and the issuer
// keeps start asserted until busy is low. done has no back-pressure.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output md_state_e        state_dbg
);

  localparam logic [5:0] CNT_LAST = 6'(MD_ITER_CNT - 1);

  md_state_e        state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Attributes of the operation in flight, captured on accept.
  logic is_div_q;
  logic neg_res_q;   // negate quotient / product
  logic neg_rem_q;   // negate remainder
  logic div0_q;      // divisor was zero

  logic             accept;
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             step;
  logic [WIDTH-1:0] it_hi, it_lo;

  assign accept    = start & ~flush & (state_q == ST_IDLE);
  assign signed_op = op_is_signed(op);
  assign a_neg     = signed_op & src_a[WIDTH-1];
  assign b_neg     = signed_op & src_b[WIDTH-1];
  assign a_abs     = a_neg ? -src_a : src_a;
  assign b_abs     = b_neg ? -src_b : src_b;

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .resetn   (resetn),
    .load_i   (accept),
    .step_i   (step),
    .is_div_i (is_div_q),
    .a_i      (a_abs),
    .b_i      (b_abs),
    .hi_o     (it_hi),
    .lo_o     (it_lo)
  );

  // Sign fixup of the finished iterative result.
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_raw = {it_hi, it_lo};
    prod_fix = neg_res_q ? -prod_raw : prod_raw;
    // Divide by zero: quotient forced to all ones; the remainder equals
    // |dividend| and its sign fixup restores the original dividend.
    quo_fix  = div0_q ? '1 : (neg_res_q ? -it_lo : it_lo);
    rem_fix  = neg_rem_q ? -it_hi : it_hi;
  end

`ifndef MULDIV_ITER_MUL_EN
  // Single-cycle multiply: operands sign-/zero-extended to full product
  // width so a plain unsigned multiply yields the correct 2*WIDTH result.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_now;

  always_comb begin
    a_ext    = {{WIDTH{a_neg}}, src_a};
    b_ext    = {{WIDTH{b_neg}}, src_b};
    prod_now = a_ext * b_ext;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    step    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (op[1]) begin
            state_d = ST_DIV;
          end else begin
`ifdef MULDIV_ITER_MUL_EN
            state_d = ST_MUL;
`else
            state_d = ST_DONE;
            hi_d    = prod_now[2*WIDTH-1:WIDTH];
            lo_d    = prod_now[WIDTH-1:0];
`endif
          end
        end
      end

      ST_MUL, ST_DIV: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      ST_FIXUP: begin
        state_d = ST_DONE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush wins over everything: abandon the operation, keep HI/LO.
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      step    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (accept) begin
        is_div_q  <= op[1];
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        div0_q    <= (src_b == '0);
      end
    end
  end

  assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                     (state_q == ST_FIXUP);
  assign done      = (state_q == ST_DONE);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed plus randomized checks of muldiv_ctrl against a
// plain-arithmetic HI/LO reference model. Honours MULDIV_ITER_MUL_EN for
// the expected multiply latency.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;
  md_state_e   state_dbg;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .state_dbg (state_dbg)
  );

`ifdef MULDIV_ITER_MUL_EN
  localparam int MUL_LAT  = 34;
  localparam int MUL_BUSY = 33;
`else
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`endif
  localparam int DIV_LAT  = 34;
  localparam int DIV_BUSY = 33;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = '0;   // HI:LO the DUT should currently hold

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: {HI, LO} from the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib, q, r;
    case (o)
      MD_MULT: begin
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
      end
      MD_MULTU: begin
        ua = a;
        ub = b;
        return ua * ub;
      end
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        q  = ia / ib;
        r  = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 2'b00;
    src_a  = '0;
    src_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Issue one op; optionally flush at sample flush_k or pulse a foreign
  // start at sample glitch_k (sample k = k-th negedge after the issue edge).
  task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int flush_k, input int glitch_k);
    logic [63:0] expv;
    int          lat, busy_cyc, lat_exp, busy_exp;
    bit          got;
    exp_q.push_back(model(o, a, b));
    lat_exp  = o[1] ? DIV_LAT : MUL_LAT;
    busy_exp = o[1] ? DIV_BUSY : MUL_BUSY;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    got = 1'b0;
    lat = 0;
    busy_cyc = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        got = 1'b1;
        lat = k;
      end else begin
        if (k == flush_k) flush = 1'b1;
        if (k == glitch_k) begin
          start = 1'b1;
          op    = ~o;
          src_a = $urandom;
          src_b = $urandom;
        end
      end
    end
    start = 1'b0;
    flush = 1'b0;
    expv  = exp_q.pop_front();
    if (flush_k > 0) begin
      chk({tag, "/no_done"}, 64'(got), 64'd0);
      chk({tag, "/busy_cycles"}, 64'(busy_cyc), 64'(flush_k));
      chk({tag, "/hilo_kept"}, {hi_out, lo_out}, last_res);
    end else begin
      chk({tag, "/done_seen"}, 64'(got), 64'd1);
      chk({tag, "/latency"}, 64'(lat), 64'(lat_exp));
      chk({tag, "/busy_cycles"}, 64'(busy_cyc), 64'(busy_exp));
      chk({tag, "/hi"}, 64'(hi_out), 64'(expv[63:32]));
      chk({tag, "/lo"}, 64'(lo_out), 64'(expv[31:0]));
      last_res = expv;
      @(negedge clk);
      chk({tag, "/done_pulse"}, 64'(done), 64'd0);
      chk({tag, "/hilo_hold"}, {hi_out, lo_out}, last_res);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    do_reset();
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/hi", 64'(hi_out), 64'd0);
    chk("reset/lo", 64'(lo_out), 64'd0);

    issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 0, 0);
    issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    issue("divu_by0", MD_DIVU, 32'h0000_1234, 32'd0, 0, 0);
    issue("div_neg_by0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0);
    issue("mult_m1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    issue("mult_mix", MD_MULT, 32'h8000_0000, 32'd3, 0, 0);
    issue("divu_flush", MD_DIVU, 32'd50000, 32'd13, 10, 0);
    issue("divu_9_3", MD_DIVU, 32'd9, 32'd3, 0, 0);
    issue("div_glitch", MD_DIV, 32'hFFFF_F000, 32'd33, 0, 5);

    // start together with flush in IDLE must not be accepted
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op    = MD_MULTU;
    src_a = 32'd3;
    src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_prio/busy", 64'(busy), 64'd0);
    chk("flush_prio/done", 64'(done), 64'd0);
    @(negedge clk);
    chk("flush_prio/done2", 64'(done), 64'd0);
    chk("flush_prio/hilo", {hi_out, lo_out}, last_res);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 100));
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      issue($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 0, 0);
    end

    // reset in the middle of a divide clears HI/LO and the FSM
    @(negedge clk);
    start = 1'b1;
    op    = MD_DIVU;
    src_a = 32'd77;
    src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    last_res = '0;
    chk("midreset/busy", 64'(busy), 64'd0);
    chk("midreset/hilo", {hi_out, lo_out}, last_res);
    issue("after_reset", MD_DIVU, 32'd77, 32'd5, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bound the whole run in case the DUT wedges.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the HI/LO resource. It accepts MULT/MULTU/DIV/DIVU issues from the execute stage and runs an iterative divider, plus a single-cycle or iterative multiplier. It holds the pipeline via `busy` and delivers a one-cycle `done` pulse carrying the HI/LO result to the write-back stage. An exception flush from write-back aborts any operation in flight.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `start`  in  1  issue request; sampled only in IDLE
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `src_a`  in  WIDTH  rs operand (multiplicand or dividend)
- `src_b`  in  WIDTH  rt operand (multiplier or divisor)
- `flush`  in  1  exception/ERET flush; aborts the current operation
- `busy`  out  1  operation in progress; the pipeline stalls EX while high
- `done`  out  1  one-cycle result-valid pulse
- `hi_out`  out  WIDTH  HI result; product[63:32] for multiply, remainder for divide
- `lo_out`  out  WIDTH  LO result; product[31:0] for multiply, quotient for divide

## Operation
- FSM states: IDLE, MUL, DIV, FIXUP, DONE.
- IDLE transitions on `start & !flush`:
  - MULT/MULTU go to MUL if `MULDIV_ITER_MUL_EN` is defined, otherwise to DONE with the product registered.
  - DIV/DIVU go to DIV.
- Operand capture: on accept, the block latches operands and the op.
  - Signed ops store absolute values plus the result-sign bit (`a[31]^b[31]`) and the remainder-sign bit (`a[31]`).
  - Unsigned ops store the raw operands with both sign bits cleared.
- DIV runs restoring division, one quotient bit per cycle, for 32 cycles. A 6-bit counter starts at 0 and leaves DIV when it reaches 31.
- MUL (iterative build only) runs shift-add, one multiplier bit per cycle, for 32 cycles. It uses the same counter.
- FIXUP applies sign correction:
  - the quotient or product is negated if the result-sign bit is set;
  - the remainder is negated if the remainder-sign bit is set.
- DONE asserts `done` for exactly one cycle, then returns to IDLE.
- `busy` = state ∈ {MUL, DIV, FIXUP}.
- `hi_out`/`lo_out` are registered. They hold their last value until the next DONE and are valid whenever `done`=1.
- Divide by zero:
  - `lo_out`=0xFFFFFFFF and `hi_out`=dividend (signed: sign-corrected magnitude, i.e. the original `src_a`).
  - Latency is the same as a normal divide.
  - No exception is raised.
- 0x80000000 / 0xFFFFFFFF signed gives `lo_out`=0x80000000, `hi_out`=0.
- Flush:
  - In any state, `flush`=1 sends the FSM to IDLE at the next edge.
  - `done` is not asserted, and `hi_out`/`lo_out` are unchanged.
  - Flush takes priority over `start` and over DONE; a flush in DONE cycle suppresses nothing already pulsed.
- `start` outside IDLE is ignored. The pipeline guarantees that it re-presents `start` while `busy`.

## Timing
- Start sampled at edge E0.
  - Divide: DIV occupies cycles E0..E31, FIXUP occupies E32, and `done` is high in the cycle after edge E33 (34-cycle latency).
  - Iterative multiply has identical latency.
  - Single-cycle multiply: `done` is high in the cycle after E0 (1-cycle latency), and `busy` stays 0.
- A back-to-back issue is accepted at the earliest in the cycle after `done`, when the FSM is back in IDLE.
- Reset values: state IDLE, `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0, counter 0.
- Reset mid-operation behaves as flush and also clears the result registers.

## Configuration
- `MULDIV_ITER_MUL_EN` defined:
  - multiply uses the shared iterative shift-add datapath, with 34-cycle latency and `busy` high;
  - this removes the 32×32 combinational multiplier.
- `MULDIV_ITER_MUL_EN` undefined: multiply uses a registered 32×32 product with 1-cycle latency, and the MUL state is unreachable.

## Structure
- The shared package holds:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`;
  - the FSM state enum;
  - the constant `MD_ITER_CNT`=32.
- One sub-module, `muldiv_iter`:
  - the 64-bit shift/subtract/add datapath step (remainder:quotient or accumulator:multiplier);
  - controlled by the FSM through `load`, `step`, and `is_div`.
- The FSM, counter, sign fixup and result registers live in `muldiv_ctrl`.

## Test plan
- DIVU 100/7 → `busy` high 33 cycles, `done` at +34, `lo_out`=14, `hi_out`=2.
- DIV 0xFFFFFFF9 (−7) / 2 → `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF; and 0x80000000/0xFFFFFFFF → `lo_out`=0x80000000, `hi_out`=0.
- DIVU 0x1234/0 → `lo_out`=0xFFFFFFFF, `hi_out`=0x1234, same 34-cycle latency.
- MULT 0xFFFFFFFF×0xFFFFFFFF → `hi_out`=0, `lo_out`=1; MULTU same operands → `hi_out`=0xFFFFFFFE, `lo_out`=1. Check 1-cycle latency without the macro and 34-cycle latency with it.
- DIVU started, `flush` at cycle 10 → `busy` low next cycle, no `done`, `hi_out`/`lo_out` keep their prior values; a new DIVU 9/3 is then accepted and yields 3/0.
- `start` pulsed during DIV with a different op → ignored; the original result is delivered unchanged.
